maze_path_checker: RTL
======================

// Module: maze_path_checker
//
// PURPOSE
//   Response-side checker for the maze solver's serial protocol. Snoops the serial maze
//   stream (in_valid/in) into an NxN bitmap, then walks the solver's direction stream
//   (out_valid/out) from start (0,0). Reports pass/fail with an error code and step count.
//   Used in the PATTERN/TESTBED environment and as an on-chip self-check for the solver.
//
// PARAMETERS
//   MAZE_N     17    maze side length; cells are row-major, bit 1 = open, 0 = wall
//   MAX_STEPS  289   accepted-step limit before overrun error (default N*N)
//   CNT_W      9     width of step counter; must hold MAX_STEPS
//
// PORTS
//   clk         in   1      single clock, rising edge
//   rst         in   1      asynchronous, active-high reset
//   in_valid    in   1      maze bit valid (solver input stream)
//   in          in   1      maze bit, row-major from (row0,col0); 1 = open
//   out_valid   in   1      direction valid (solver output stream)
//   out         in   2      direction: 0 right(col+1), 1 down(row+1), 2 left, 3 up
//   done        out  1      one-cycle pulse: verdict valid
//   pass        out  1      path legal and ends on goal (N-1,N-1); held until next load
//   err_code    out  2      0 none, 1 wall hit, 2 out of bounds, 3 overrun/incomplete; held
//   step_count  out  CNT_W  steps accepted in the last walk, saturates at MAX_STEPS; held
//
// BEHAVIOUR
//   Reset: state=IDLE; done=0, pass=0, err_code=0, step_count=0; bitmap contents don't-care.
//   FSM states: IDLE, LOAD, WAIT, WALK, REPORT.
//   IDLE: in_valid=1 -> LOAD; captures first bit at (0,0); clears pass/err_code/step_count.
//   LOAD: one bit per in_valid cycle; row/col counters wrap col at N-1 -> row+1.
//     - N*N-th bit captured -> WAIT (same edge).
//     - in_valid drops before N*N bits -> abort to IDLE, no done pulse, outputs stay cleared.
//     - out_valid=1 during LOAD -> ignored.
//   WAIT: pos=(0,0), err latch=0, step_count=0. out_valid=1 -> WALK, first step processed that cycle.
//     - in_valid=1 in WAIT -> new load starts (back to LOAD), previous bitmap discarded.
//   WALK: each out_valid cycle = one step, evaluated combinationally from current pos:
//     - move leaves grid (col/row <0 or >N-1) -> err 2, pos unchanged.
//     - target cell = 0 -> err 1, pos unchanged.
//     - step while pos already == goal -> err 3 (steps past goal).
//     - step_count reaches MAX_STEPS and another step arrives -> err 3.
//     - first error latched; later steps still counted but never overwrite err_code.
//     - legal step: pos <= target, step_count +1.
//   out_valid falls in WALK -> REPORT. If no error and pos != goal -> err 3.
//   REPORT (one cycle): done=1; pass=1 iff err_code==0. -> IDLE.
//   Latency: done asserted exactly 1 cycle after the first cycle with out_valid=0.
//   Start cell (0,0) wall bit is not checked; goal cell bit is checked like any target.
//   rst asserted mid-LOAD or mid-WALK: immediate return to reset values, no done pulse.
//
// TESTING
//   1. 17x17 maze, straight open corridor row0 then col16; 16x dir0 then 16x dir1 -> done 1 cycle
//      after out_valid falls, pass=1, err_code=0, step_count=32.
//   2. Same maze, path whose 5th step enters a 0 cell -> pass=0, err_code=1, step_count=total steps sent.
//   3. First step dir3 (up) from (0,0) -> err_code=2, pass=0; later legal steps do not clear it.
//   4. Legal path stopping at (16,15) -> err_code=3; legal path + 1 extra step past goal -> err_code=3.
//   5. in_valid drops after 100 bits -> no done, back to IDLE; full reload then valid walk -> pass=1.
//   6. rst pulse during WALK step 10 -> done=0, pass=0, err_code=0, step_count=0 next cycle; new run passes.

Source files
------------

// File: rtl/maze_path_checker.sv
// rtl/maze_path_checker.sv - snoops a serial maze bitmap and verifies the solver's direction stream against it
module maze_path_checker #(
  parameter int MAZE_N    = 17,
  parameter int MAX_STEPS = 289,
  parameter int CNT_W     = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             out_valid,
  input  logic [1:0]       out,
  output logic             done,
  output logic             pass,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] step_count
);

  localparam int CELLS = MAZE_N * MAZE_N;
  localparam int POS_W = (MAZE_N > 1) ? $clog2(MAZE_N) : 1;
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  localparam logic [POS_W-1:0] LAST     = POS_W'(MAZE_N - 1);
  localparam logic [POS_W-1:0] FIRST    = '0;
  localparam logic [CNT_W-1:0] STEP_MAX = CNT_W'(MAX_STEPS);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_WALL    = 2'd1;
  localparam logic [1:0] ERR_BOUNDS  = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_UP    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_WALK,
    S_REPORT
  } state_t;

  state_t           state;
  logic [CELLS-1:0] bitmap;

  // load write pointer (row/col of the next maze bit)
  logic [POS_W-1:0] ld_row;
  logic [POS_W-1:0] ld_col;

  // current walker position
  logic [POS_W-1:0] row;
  logic [POS_W-1:0] col;

  // step evaluation
  logic [POS_W-1:0] tgt_row;
  logic [POS_W-1:0] tgt_col;
  logic             off_grid;
  logic             tgt_open;
  logic             at_goal;
  logic             at_limit;
  logic [1:0]       step_err;
  logic [1:0]       err_nxt;
  logic [1:0]       final_err;
  logic [CNT_W-1:0] cnt_nxt;

  // bitmap write port
  logic             load_we;
  logic             load_last;
  logic [IDX_W-1:0] load_idx;

  function automatic logic [IDX_W-1:0] cell_idx(input logic [POS_W-1:0] r,
                                                input logic [POS_W-1:0] c);
    return IDX_W'(r) * IDX_W'(MAZE_N) + IDX_W'(c);
  endfunction

  // A maze bit is stored whenever a load is starting or running; a fresh load always starts at cell (0,0)
  always_comb begin
    load_we   = 1'b0;
    load_idx  = '0;
    load_last = (ld_row == LAST) && (ld_col == LAST);
    case (state)
      S_IDLE, S_WAIT: load_we = in_valid;
      S_LOAD: begin
        load_we  = in_valid;
        load_idx = cell_idx(ld_row, ld_col);
      end
      default: load_we = 1'b0;
    endcase
  end

  // Bitmap storage; contents are meaningless until a full load completes, so no reset
  always_ff @(posedge clk) begin
    if (load_we) begin
      bitmap[load_idx] <= in;
    end
  end

  // Target cell of the requested move, and whether the move would leave the grid
  always_comb begin
    tgt_row  = row;
    tgt_col  = col;
    off_grid = 1'b0;
    case (out)
      DIR_RIGHT: if (col == LAST)  off_grid = 1'b1; else tgt_col = col + 1'b1;
      DIR_DOWN:  if (row == LAST)  off_grid = 1'b1; else tgt_row = row + 1'b1;
      DIR_LEFT:  if (col == FIRST) off_grid = 1'b1; else tgt_col = col - 1'b1;
      DIR_UP:    if (row == FIRST) off_grid = 1'b1; else tgt_row = row - 1'b1;
      default:   off_grid = 1'b0;
    endcase
  end

  // Classify the step; stepping past the goal or past the step limit outranks a geometric error
  always_comb begin
    tgt_open = bitmap[cell_idx(tgt_row, tgt_col)];
    at_goal  = (row == LAST) && (col == LAST);
    at_limit = (step_count == STEP_MAX);
    step_err = ERR_NONE;
    if (at_goal || at_limit) begin
      step_err = ERR_OVERRUN;
    end else if (off_grid) begin
      step_err = ERR_BOUNDS;
    end else if (!tgt_open) begin
      step_err = ERR_WALL;
    end
    err_nxt   = (err_code != ERR_NONE) ? err_code : step_err;
    cnt_nxt   = at_limit ? step_count : step_count + 1'b1;
    final_err = ((err_code == ERR_NONE) && !at_goal) ? ERR_OVERRUN : err_code;
  end

  // Protocol FSM: load the bitmap, walk the direction stream, then report a one-cycle verdict
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_code   <= ERR_NONE;
      step_count <= '0;
      ld_row     <= '0;
      ld_col     <= '0;
      row        <= '0;
      col        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            pass       <= 1'b0;
            err_code   <= ERR_NONE;
            step_count <= '0;
            ld_row     <= '0;
            ld_col     <= POS_W'(1);
            state      <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (!in_valid) begin
            state <= S_IDLE;
          end else if (load_last) begin
            row        <= '0;
            col        <= '0;
            err_code   <= ERR_NONE;
            step_count <= '0;
            state      <= S_WAIT;
          end else if (ld_col == LAST) begin
            ld_col <= '0;
            ld_row <= ld_row + 1'b1;
          end else begin
            ld_col <= ld_col + 1'b1;
          end
        end

        S_WAIT: begin
          if (in_valid) begin
            ld_row <= '0;
            ld_col <= POS_W'(1);
            state  <= S_LOAD;
          end else if (out_valid) begin
            step_count <= cnt_nxt;
            err_code   <= err_nxt;
            if (step_err == ERR_NONE) begin
              row <= tgt_row;
              col <= tgt_col;
            end
            state <= S_WALK;
          end
        end

        S_WALK: begin
          if (out_valid) begin
            step_count <= cnt_nxt;
            err_code   <= err_nxt;
            if (step_err == ERR_NONE) begin
              row <= tgt_row;
              col <= tgt_col;
            end
          end else begin
            err_code <= final_err;
            pass     <= (final_err == ERR_NONE);
            done     <= 1'b1;
            state    <= S_REPORT;
          end
        end

        S_REPORT: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
